// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the two-requester ALU arbiter and its ALU core:
//   ALU_W              default operand/result width
//   OP_AND .. OP_SUB   3-bit opcodes understood by alu_core
//   state_e            arbiter FSM state encoding (ST_IDLE/ST_EXEC/ST_RESP)
//   op_is_legal()      true for opcodes 000..101
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_W = 32;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOR = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic op_is_legal(input logic [2:0] op);
      return (op <= OP_SUB);
   endfunction

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational ALU shared by the arbiter.
// Ports:
//   a, b   in  WIDTH  operands
//   op     in  3      opcode (see alu_pkg)
//   s      out WIDTH  result (0 for illegal opcodes)
//   eq     out 1      a == b, computed for every opcode
//   cary   out 1      carry-out of ADD/SUB (SUB: 1 means no borrow), else 0
//   of     out 1      signed overflow of ADD/SUB, else 0
//   err    out 1      opcode 110/111
// ---------------------------------------------------------------------------
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_W
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] s,
   output logic             eq,
   output logic             cary,
   output logic             of,
   output logic             err
);

   localparam logic [WIDTH:0] ONE_W1 = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH:0] sum_add;
   logic [WIDTH:0] sum_sub;
   logic           of_add;
   logic           of_sub;

   // Both arithmetic paths are one bit wider so the top bit is the carry.
   assign sum_add = {1'b0, a} + {1'b0, b};
   assign sum_sub = {1'b0, a} + {1'b0, ~b} + ONE_W1;

   // Overflow: operands that can produce an out-of-range result, and the
   // result sign disagrees with operand a.
   assign of_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
   assign of_sub = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);

   assign eq  = (a == b);
   assign err = !op_is_legal(op);

   always_comb begin
      s    = '0;
      cary = 1'b0;
      of   = 1'b0;
      case (op)
         OP_AND: s = a & b;
         OP_OR:  s = a | b;
         OP_XOR: s = a ^ b;
         OP_NOR: s = ~(a | b);
         OP_ADD: begin
            s    = sum_add[WIDTH-1:0];
            cary = sum_add[WIDTH];
            of   = of_add;
         end
         OP_SUB: begin
            s    = sum_sub[WIDTH-1:0];
            cary = sum_sub[WIDTH];
            of   = of_sub;
         end
         default: begin
            s    = '0;
            cary = 1'b0;
            of   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
// Shares one alu_core between two valid/ready requesters. A round-robin FSM
// grants one request, latches its operands, executes it and returns the
// tagged result on a single response channel.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          request handshake per requester (N = 0,1)
//   reqN_op/a/b               opcode and operands per requester
//   rsp_valid/ready           response handshake
//   rsp_id                    requester that owns the response
//   rsp_result                ALU result
//   rsp_eq/carry/of/err       flags (a==b, carry-out, signed overflow, bad op)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a request; ready given to the granted requester
// ST_EXEC  | latched operands feed the ALU; result registered at the edge
// ST_RESP  | response held valid until rsp_ready, then pointer advances
// ---------------------------------------------------------------------------
module alu_req_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_W
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,

   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_eq,
   output logic             rsp_carry,
   output logic             rsp_of,
   output logic             rsp_err
);

   state_e           state_q;
   logic             rr_ptr_q;

   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             id_q;

   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic             rsp_eq_q;
   logic             rsp_carry_q;
   logic             rsp_of_q;
   logic             rsp_err_q;

   logic             any_valid;
   logic             grant_id;
   logic             accept;
   logic [2:0]       grant_op;
   logic [WIDTH-1:0] grant_a;
   logic [WIDTH-1:0] grant_b;

   logic [WIDTH-1:0] alu_s;
   logic             alu_eq;
   logic             alu_cary;
   logic             alu_of;
   logic             alu_err;

   // Round-robin only matters when both ask; a lone requester always wins.
   assign any_valid = req0_valid | req1_valid;
   assign grant_id  = (req0_valid & req1_valid) ? rr_ptr_q : req1_valid;

   // Ready is held low while rst is asserted so nothing is accepted during
   // a reset that spans several cycles.
   assign accept     = !rst && (state_q == ST_IDLE) && any_valid;
   assign req0_ready = accept & ~grant_id;
   assign req1_ready = accept &  grant_id;

   assign grant_op = grant_id ? req1_op : req0_op;
   assign grant_a  = grant_id ? req1_a  : req0_a;
   assign grant_b  = grant_id ? req1_b  : req0_b;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_alu_core (
      .a    (a_q),
      .b    (b_q),
      .op   (op_q),
      .s    (alu_s),
      .eq   (alu_eq),
      .cary (alu_cary),
      .of   (alu_of),
      .err  (alu_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= 1'b0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_eq_q     <= 1'b0;
         rsp_carry_q  <= 1'b0;
         rsp_of_q     <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q    <= grant_op;
                  a_q     <= grant_a;
                  b_q     <= grant_b;
                  id_q    <= grant_id;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_result_q <= alu_s;
               rsp_eq_q     <= alu_eq;
               rsp_carry_q  <= alu_cary;
               rsp_of_q     <= alu_of;
               rsp_err_q    <= alu_err;
               rsp_id_q     <= id_q;
               rsp_valid_q  <= 1'b1;
               state_q      <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  // The requester just served drops to lowest priority.
                  rr_ptr_q    <= ~rsp_id_q;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_eq     = rsp_eq_q;
   assign rsp_carry  = rsp_carry_q;
   assign rsp_of     = rsp_of_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;

   logic        clk;
   logic        rst;
   logic        req0_valid, req0_ready;
   logic [2:0]  req0_op;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [2:0]  req1_op;
   logic [31:0] req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_result;
   logic        rsp_eq, rsp_carry, rsp_of, rsp_err;

   int checks;
   int errors;

   alu_req_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_eq     (rsp_eq),
      .rsp_carry  (rsp_carry),
      .rsp_of     (rsp_of),
      .rsp_err    (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        eq;
      logic        c;
      logic        of;
      logic        err;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic grant_check(input string nm, input logic exp_id);
      chk({nm, "_ready0"}, {31'd0, req0_ready}, {31'd0, (exp_id == 1'b0)});
      chk({nm, "_ready1"}, {31'd0, req1_ready}, {31'd0, (exp_id == 1'b1)});
   endtask

   // Called in the cycle where ready is high; completes the transaction and
   // returns in the following IDLE cycle.
   task automatic finish_txn(input string nm, input logic [31:0] er, input logic eid,
                             input logic eeq, input logic ec, input logic eof, input logic eerr);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk({nm, "_exec_valid"}, {31'd0, rsp_valid}, 32'd0);
      step();
      #1;
      chk({nm, "_valid"},  {31'd0, rsp_valid}, 32'd1);
      chk({nm, "_id"},     {31'd0, rsp_id},    {31'd0, eid});
      chk({nm, "_result"}, rsp_result,         er);
      chk({nm, "_eq"},     {31'd0, rsp_eq},    {31'd0, eeq});
      chk({nm, "_carry"},  {31'd0, rsp_carry}, {31'd0, ec});
      chk({nm, "_of"},     {31'd0, rsp_of},    {31'd0, eof});
      chk({nm, "_err"},    {31'd0, rsp_err},   {31'd0, eerr});
      chk({nm, "_resp_rdy"}, {30'd0, req0_ready, req1_ready}, 32'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      #1;
      chk({nm, "_done"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;

      //            op      a             b             res           eq    c     of    err
      vecs[0] = '{3'b001, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{3'b010, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{3'b011, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{3'b101, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{3'b101, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{3'b111, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[8] = '{3'b110, 32'h00000001, 32'h00000002, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};

      rst = 1'b1;
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_op = 3'b100; req0_a = 32'h7FFFFFFF; req0_b = 32'h00000001;
      req1_valid = 1'b1; req1_op = 3'b101; req1_a = 32'h00000005; req1_b = 32'h00000005;

      // Reset held two cycles with both requesters asking.
      step();
      step();
      #1;
      chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
      chk("rst_valid",  {31'd0, rsp_valid},  32'd0);
      chk("rst_result", rsp_result,          32'd0);

      // Contention straight out of reset: grants go 0, 1, 0.
      rst = 1'b0;
      #1;
      grant_check("cont0", 1'b0);
      finish_txn("cont0", 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      grant_check("cont1", 1'b1);
      finish_txn("cont1", 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      grant_check("cont2", 1'b0);
      finish_txn("cont2", 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Backpressure: response held for 5 cycles while req1 waits.
      req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'hA5A5A5A5; req0_b = 32'h0F0F0F0F;
      #1;
      grant_check("bp", 1'b0);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_op = 3'b010; req1_a = 32'h00000001; req1_b = 32'h00000003;
      step();
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_valid",  {31'd0, rsp_valid}, 32'd1);
         chk("bp_result", rsp_result, 32'h05050505);
         chk("bp_id",     {31'd0, rsp_id}, 32'd0);
         chk("bp_rdy",    {30'd0, req0_ready, req1_ready}, 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      #1;
      chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
      grant_check("bp_next", 1'b1);
      finish_txn("bp_next", 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Directed vector table, alternating single requesters.
      for (int i = 0; i < 9; i++) begin
         if (i % 2 == 0) begin
            req0_valid = 1'b1; req0_op = vecs[i].op; req0_a = vecs[i].a; req0_b = vecs[i].b;
         end else begin
            req1_valid = 1'b1; req1_op = vecs[i].op; req1_a = vecs[i].a; req1_b = vecs[i].b;
         end
         #1;
         grant_check($sformatf("vec%0d", i), (i % 2 == 1));
         finish_txn($sformatf("vec%0d", i), vecs[i].res, (i % 2 == 1),
                    vecs[i].eq, vecs[i].c, vecs[i].of, vecs[i].err);
      end

      // Reset during EXEC: no response, pointer back to req0 (it was 1 here).
      req1_valid = 1'b1; req1_op = 3'b101; req1_a = 32'd9; req1_b = 32'd4;
      #1;
      grant_check("rstx", 1'b1);
      step();
      req1_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("rstx_novalid", {31'd0, rsp_valid}, 32'd0);
         step();
      end
      req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'd1; req0_b = 32'd2;
      req1_valid = 1'b1;
      #1;
      grant_check("rstx_after", 1'b0);
      finish_txn("rstx_after", 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset during RESP drops the pending response.
      req0_valid = 1'b1; req0_op = 3'b100; req0_a = 32'd2; req0_b = 32'd3;
      #1;
      grant_check("rstr", 1'b0);
      step();
      req0_valid = 1'b0;
      step();
      #1;
      chk("rstr_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rstr_result", rsp_result, 32'd5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("rstr_cleared", {31'd0, rsp_valid}, 32'd0);
      chk("rstr_result0", rsp_result, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
